// File: rtl/cpu_types_pkg.sv
// Shared CPU datapath types, plus the state, grant record and error word used by the
// instruction/data memory arbiter.
package cpu_types_pkg;

    typedef logic [31:0] word_t;

    typedef enum logic [1:0] {
        FREE   = 2'd0,
        BUSY   = 2'd1,
        ACCESS = 2'd2,
        ERROR  = 2'd3
    } ramstate_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        IACC = 2'd1,
        DACC = 2'd2
    } arb_state_t;

    localparam word_t ARB_ERR_DATA = 32'hBAD0_BAD0;

    // Everything the RAM side needs is captured here so it never sees live requester inputs.
    typedef struct packed {
        word_t addr;
        word_t data;
        logic  write;
    } arb_grant_t;

    function automatic logic [3:0] streakInc(input logic [3:0] cur, input logic [3:0] lim);
        if (cur >= lim) begin
            return lim;
        end else begin
            return cur + 4'd1;
        end
    endfunction

endpackage

// File: rtl/arb_watchdog.sv
// Access watchdog: counts cycles spent in an access state and flags when the limit is hit.
module arb_watchdog
    import cpu_types_pkg::*;
#(
    parameter int unsigned TIMEOUT = 255
) (
    input  logic CLK,
    input  logic nRST,
    input  logic clr,
    input  logic en,
    output logic expired
);

    localparam logic [7:0] LIMIT = 8'(TIMEOUT);

    logic [7:0] count_r;

    // Cycle counter, saturating at the limit so a late abort cannot wrap it.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            count_r <= 8'd0;
        end else if (clr) begin
            count_r <= 8'd0;
        end else if (en && (count_r != LIMIT)) begin
            count_r <= count_r + 8'd1;
        end else begin
            count_r <= count_r;
        end
    end

    assign expired = en && (count_r == LIMIT);

endmodule

// File: rtl/mem_arbiter.sv
// Single-port RAM arbiter between the instruction and data paths: data has priority,
// a streak limit protects instruction fetch, and a watchdog aborts a hung RAM.
module mem_arbiter
    import cpu_types_pkg::*;
#(
    parameter int unsigned MAX_D_STREAK = 4,
    parameter int unsigned TIMEOUT      = 255
) (
    input  logic      CLK,
    input  logic      nRST,
    input  logic      iREN,
    input  word_t     iaddr,
    output word_t     iload,
    output logic      iwait,
    input  logic      dREN,
    input  logic      dWEN,
    input  word_t     daddr,
    input  word_t     dstore,
    output word_t     dload,
    output logic      dwait,
    output logic      ramREN,
    output logic      ramWEN,
    output word_t     ramaddr,
    output word_t     ramstore,
    input  word_t     ramload,
    input  ramstate_t ramstate,
    output logic      bus_err
);

    localparam logic [3:0] STREAK_LIM = 4'(MAX_D_STREAK);

    arb_state_t state_r;
    arb_state_t nextState_s;
    arb_grant_t grant_r;
    arb_grant_t grantNext_s;
    logic [3:0] streak_r;
    logic [3:0] streakNext_s;
    logic       abort_r;
    logic       abortNext_s;
    logic       ramREN_r;
    logic       ramRENNext_s;
    logic       ramWEN_r;
    logic       ramWENNext_s;
    logic       iwait_r;
    logic       iwaitNext_s;
    logic       dwait_r;
    logic       dwaitNext_s;
    word_t      iload_r;
    word_t      iloadNext_s;
    word_t      dload_r;
    word_t      dloadNext_s;
    logic       busErr_r;
    logic       busErrNext_s;

    logic inAccess_s;
    logic dReq_s;
    logic canGrant_s;
    logic dataFirst_s;
    logic grantD_s;
    logic grantI_s;
    logic mismatch_s;
    logic done_s;
    logic fault_s;
    logic wdExpired_s;

    assign inAccess_s  = (state_r == IACC) || (state_r == DACC);
    assign dReq_s      = dREN | dWEN;
    // The IDLE cycle that releases a wait never grants: the released requester is still
    // showing its old request there.
    assign canGrant_s  = (state_r == IDLE) & iwait_r & dwait_r;
    assign dataFirst_s = dReq_s & ~(iREN & (streak_r >= STREAK_LIM));
    assign grantD_s    = canGrant_s & dataFirst_s;
    assign grantI_s    = canGrant_s & ~dataFirst_s & iREN;
    assign mismatch_s  = (state_r == IACC) ? (~iREN | (iaddr != grant_r.addr)) :
                         (state_r == DACC) ? (~dReq_s | (daddr != grant_r.addr)) : 1'b0;
    assign done_s      = inAccess_s & (ramstate == ACCESS);
    assign fault_s     = inAccess_s & ((ramstate == ERROR) | wdExpired_s);

    arb_watchdog #(
        .TIMEOUT (TIMEOUT)
    ) uWatchdog (
        .CLK     (CLK),
        .nRST    (nRST),
        .clr     (~inAccess_s),
        .en      (inAccess_s),
        .expired (wdExpired_s)
    );

    // FSM state register.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state_r <= IDLE;
        end else begin
            state_r <= nextState_s;
        end
    end

    // Next-state decision.
    always_comb begin
        nextState_s = state_r;
        case (state_r)
            IDLE: begin
                if (grantD_s) begin
                    nextState_s = DACC;
                end else if (grantI_s) begin
                    nextState_s = IACC;
                end else begin
                    nextState_s = IDLE;
                end
            end
            IACC, DACC: begin
                if (fault_s || done_s) begin
                    nextState_s = IDLE;
                end else begin
                    nextState_s = state_r;
                end
            end
            default: nextState_s = IDLE;
        endcase
    end

    // Next values of grant, streak, strobes, waits, load data and error flag.
    always_comb begin
        grantNext_s  = grant_r;
        streakNext_s = streak_r;
        abortNext_s  = abort_r;
        ramRENNext_s = ramREN_r;
        ramWENNext_s = ramWEN_r;
        iwaitNext_s  = 1'b1;
        dwaitNext_s  = 1'b1;
        iloadNext_s  = iload_r;
        dloadNext_s  = dload_r;
        busErrNext_s = busErr_r;
        case (state_r)
            IDLE: begin
                abortNext_s = 1'b0;
                if (grantD_s) begin
                    grantNext_s  = '{addr: daddr, data: dstore, write: dWEN};
                    ramRENNext_s = ~dWEN;
                    ramWENNext_s = dWEN;
                    streakNext_s = iREN ? streakInc(streak_r, STREAK_LIM) : 4'd0;
                end else if (grantI_s) begin
                    grantNext_s  = '{addr: iaddr, data: 32'h0000_0000, write: 1'b0};
                    ramRENNext_s = 1'b1;
                    ramWENNext_s = 1'b0;
                    streakNext_s = 4'd0;
                end else begin
                    ramRENNext_s = 1'b0;
                    ramWENNext_s = 1'b0;
                    streakNext_s = iREN ? streak_r : 4'd0;
                end
            end
            IACC, DACC: begin
                if (fault_s) begin
                    ramRENNext_s = 1'b0;
                    ramWENNext_s = 1'b0;
                    busErrNext_s = 1'b1;
                    if (state_r == IACC) begin
                        iwaitNext_s = 1'b0;
                        iloadNext_s = ARB_ERR_DATA;
                    end else begin
                        dwaitNext_s = 1'b0;
                        dloadNext_s = ARB_ERR_DATA;
                    end
                end else if (done_s) begin
                    ramRENNext_s = 1'b0;
                    ramWENNext_s = 1'b0;
                    if (!(abort_r | mismatch_s)) begin
                        if (state_r == IACC) begin
                            iwaitNext_s = 1'b0;
                            iloadNext_s = ramload;
                        end else begin
                            dwaitNext_s = 1'b0;
                            dloadNext_s = grant_r.write ? dload_r : ramload;
                        end
                    end else begin
                        abortNext_s = 1'b1;
                    end
                end else begin
                    abortNext_s = abort_r | mismatch_s;
                end
            end
            default: begin
                ramRENNext_s = 1'b0;
                ramWENNext_s = 1'b0;
            end
        endcase
    end

    // Registered outputs and grant/streak bookkeeping.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            grant_r  <= '{addr: 32'h0000_0000, data: 32'h0000_0000, write: 1'b0};
            streak_r <= 4'd0;
            abort_r  <= 1'b0;
            ramREN_r <= 1'b0;
            ramWEN_r <= 1'b0;
            iwait_r  <= 1'b1;
            dwait_r  <= 1'b1;
            iload_r  <= 32'h0000_0000;
            dload_r  <= 32'h0000_0000;
            busErr_r <= 1'b0;
        end else begin
            grant_r  <= grantNext_s;
            streak_r <= streakNext_s;
            abort_r  <= abortNext_s;
            ramREN_r <= ramRENNext_s;
            ramWEN_r <= ramWENNext_s;
            iwait_r  <= iwaitNext_s;
            dwait_r  <= dwaitNext_s;
            iload_r  <= iloadNext_s;
            dload_r  <= dloadNext_s;
            busErr_r <= busErrNext_s;
        end
    end

    assign ramREN   = ramREN_r;
    assign ramWEN   = ramWEN_r;
    assign ramaddr  = grant_r.addr;
    assign ramstore = grant_r.data;
    assign iwait    = iwait_r;
    assign dwait    = dwait_r;
    assign iload    = iload_r;
    assign dload    = dload_r;
    assign bus_err  = busErr_r;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: a small RAM model answers the strobes and a pair of
// scoreboard queues hold the load value expected at each wait release.
module tb_mem_arbiter;
    import cpu_types_pkg::*;

    logic      CLK;
    logic      nRST;
    logic      iREN;
    word_t     iaddr;
    word_t     iload;
    logic      iwait;
    logic      dREN;
    logic      dWEN;
    word_t     daddr;
    word_t     dstore;
    word_t     dload;
    logic      dwait;
    logic      ramREN;
    logic      ramWEN;
    word_t     ramaddr;
    word_t     ramstore;
    word_t     ramload;
    ramstate_t ramstate;
    logic      bus_err;

    word_t      mem [0:63];
    logic [7:0] ramCnt;
    logic [7:0] ramLat;
    logic       ramStuck;

    word_t iExp[$];
    word_t dExp[$];
    int    checks = 0;
    int    errors = 0;
    int    strobeCnt = 0;
    word_t lastAddr = 32'h0;
    logic  iwaitPrev = 1'b1;
    logic  dwaitPrev = 1'b1;

    mem_arbiter #(.MAX_D_STREAK(4), .TIMEOUT(255)) dut (
        .CLK(CLK), .nRST(nRST),
        .iREN(iREN), .iaddr(iaddr), .iload(iload), .iwait(iwait),
        .dREN(dREN), .dWEN(dWEN), .daddr(daddr), .dstore(dstore), .dload(dload), .dwait(dwait),
        .ramREN(ramREN), .ramWEN(ramWEN), .ramaddr(ramaddr), .ramstore(ramstore),
        .ramload(ramload), .ramstate(ramstate), .bus_err(bus_err)
    );

    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    // RAM model: BUSY for ramLat cycles after the strobe rises, then ACCESS.
    always_comb begin
        if (!(ramREN | ramWEN)) ramstate = FREE;
        else if (ramStuck) ramstate = BUSY;
        else if (ramCnt >= ramLat) ramstate = ACCESS;
        else ramstate = BUSY;
    end

    assign ramload = mem[ramaddr[7:2]];

    always_ff @(posedge CLK) begin
        if (!(ramREN | ramWEN) || (ramstate == ACCESS)) ramCnt <= 8'd0;
        else if (ramCnt != 8'hFF) ramCnt <= ramCnt + 8'd1;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // One cycle: sample at the falling edge, apply RAM writes, score any wait release.
    task automatic tick();
        @(negedge CLK);
        if (ramREN | ramWEN) begin
            strobeCnt++;
            lastAddr = ramaddr;
            if (ramWEN && (ramstate == ACCESS)) mem[ramaddr[7:2]] = ramstore;
        end
        if (!iwait) begin
            check("iwait_pulse", {31'b0, iwaitPrev}, 32'd1);
            if (iExp.size() == 0) check("iwait_unexpected", {31'b0, iwait}, 32'd1);
            else check("iload", iload, iExp.pop_front());
        end
        if (!dwait) begin
            check("dwait_pulse", {31'b0, dwaitPrev}, 32'd1);
            if (dExp.size() == 0) check("dwait_unexpected", {31'b0, dwait}, 32'd1);
            else check("dload", dload, dExp.pop_front());
        end
        iwaitPrev = iwait;
        dwaitPrev = dwait;
    endtask

    task automatic waitRel(input bit isData, input int maxCyc, output int n);
        logic w;
        n = 0;
        do begin
            tick();
            n++;
            w = isData ? dwait : iwait;
        end while (w && (n < maxCyc));
        if (w) begin
            if (isData) check("dwait_timeout", {31'b0, dwait}, 32'd0);
            else check("iwait_timeout", {31'b0, iwait}, 32'd0);
        end
    endtask

    initial begin
        int n;
        int dDone;
        bit seen;
        for (int i = 0; i < 64; i++) mem[i] = 32'h1000_0000 + i * 32'h0000_0101;
        mem[16] = 32'h2108_0004;
        ramLat = 8'd0; ramStuck = 1'b0;
        nRST = 1'b0; iREN = 1'b0; iaddr = 32'h0; dREN = 1'b0; dWEN = 1'b0;
        daddr = 32'h0; dstore = 32'h0;
        tick(); tick();
        check("rst_iwait", {31'b0, iwait}, 32'd1);
        check("rst_dwait", {31'b0, dwait}, 32'd1);
        check("rst_ramREN", {31'b0, ramREN}, 32'd0);
        check("rst_ramWEN", {31'b0, ramWEN}, 32'd0);
        check("rst_ramaddr", ramaddr, 32'h0);
        check("rst_ramstore", ramstore, 32'h0);
        check("rst_iload", iload, 32'h0);
        check("rst_dload", dload, 32'h0);
        check("rst_bus_err", {31'b0, bus_err}, 32'd0);
        nRST = 1'b1;
        tick();

        // Single instruction read with a one-cycle RAM.
        iREN = 1'b1; iaddr = 32'h40; iExp.push_back(32'h2108_0004);
        tick();
        check("t1_ramREN", {31'b0, ramREN}, 32'd1);
        check("t1_ramWEN", {31'b0, ramWEN}, 32'd0);
        check("t1_ramaddr", ramaddr, 32'h40);
        waitRel(1'b0, 20, n);
        check("t1_latency", 32'(n + 1), 32'd2);
        iREN = 1'b0;
        tick();

        // Simultaneous instr read and data write: data first, then a bubble, then instr.
        iREN = 1'b1; iaddr = 32'h48; iExp.push_back(mem[18]);
        dREN = 1'b1; dWEN = 1'b1; daddr = 32'h80; dstore = 32'hDEAD_BEEF;
        dExp.push_back(32'h0);   // a write leaves dload at its reset value
        tick();
        check("t2_ramWEN", {31'b0, ramWEN}, 32'd1);
        check("t2_ramREN", {31'b0, ramREN}, 32'd0);
        check("t2_ramaddr", ramaddr, 32'h80);
        check("t2_ramstore", ramstore, 32'hDEAD_BEEF);
        waitRel(1'b1, 20, n);
        dREN = 1'b0; dWEN = 1'b0;
        waitRel(1'b0, 20, n);
        check("t2_instr_after_bubble", 32'(n), 32'd3);
        check("t2_instr_addr", lastAddr, 32'h48);
        iREN = 1'b0;
        tick();

        // Streak limit: continuous data reads against a waiting instr fetch.
        ramLat = 8'd1;
        iREN = 1'b1; iaddr = 32'h4C; iExp.push_back(mem[19]);
        dREN = 1'b1; daddr = 32'h0; dExp.push_back(mem[0]);
        dDone = 0; seen = 1'b0;
        for (int k = 0; (k < 200) && !seen; k++) begin
            tick();
            if (!dwait) begin
                dDone++;
                daddr = daddr + 32'd4;
                dExp.push_back(mem[daddr[7:2]]);
            end
            if (!iwait) seen = 1'b1;
        end
        check("t3_instr_served", {31'b0, seen}, 32'd1);
        check("t3_data_streak", 32'(dDone), 32'd4);
        check("t3_streak_cleared", 32'(dut.streak_r), 32'd0);
        iREN = 1'b0;
        waitRel(1'b1, 20, n);
        dREN = 1'b0;
        tick(); tick();

        // Address change while the RAM is busy: first access discarded, 0x44 served.
        ramLat = 8'd3;
        iREN = 1'b1; iaddr = 32'h40;
        tick();
        check("t4_first_addr", ramaddr, 32'h40);
        iaddr = 32'h44; iExp.push_back(mem[17]);
        waitRel(1'b0, 40, n);
        check("t4_reissue_addr", lastAddr, 32'h44);
        iREN = 1'b0;
        tick();

        // Hung RAM: watchdog fires after 256 strobe cycles.
        ramStuck = 1'b1; strobeCnt = 0;
        dREN = 1'b1; dWEN = 1'b0; daddr = 32'h90; dExp.push_back(32'hBAD0_BAD0);
        waitRel(1'b1, 400, n);
        check("t5_strobe_cycles", 32'(strobeCnt), 32'd256);
        check("t5_bus_err", {31'b0, bus_err}, 32'd1);
        check("t5_strobe_dropped", {30'b0, ramREN, ramWEN}, 32'd0);
        check("t5_state_idle", 32'(dut.state_r), 32'(IDLE));
        dREN = 1'b0; ramStuck = 1'b0;
        tick();
        check("t5_bus_err_sticky", {31'b0, bus_err}, 32'd1);

        // Reset in the middle of a data access.
        ramLat = 8'd3;
        dREN = 1'b1; daddr = 32'h84;
        tick();
        check("t6_pre_ramREN", {31'b0, ramREN}, 32'd1);
        nRST = 1'b0;
        #1;
        check("t6_ramREN", {31'b0, ramREN}, 32'd0);
        check("t6_ramWEN", {31'b0, ramWEN}, 32'd0);
        check("t6_iwait", {31'b0, iwait}, 32'd1);
        check("t6_dwait", {31'b0, dwait}, 32'd1);
        check("t6_bus_err", {31'b0, bus_err}, 32'd0);
        tick();
        nRST = 1'b1;
        ramLat = 8'd1;
        daddr = 32'h80; dExp.push_back(32'hDEAD_BEEF);
        waitRel(1'b1, 20, n);
        check("t6_fresh_latency", 32'(n), 32'd3);
        dREN = 1'b0;
        tick();
        check("t6_bus_err_after", {31'b0, bus_err}, 32'd0);
        check("queues_drained", 32'(iExp.size() + dExp.size()), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL global_timeout observed=running expected=finished");
        $fatal(1, "bench timeout");
    end

endmodule
